// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control sequencer for a multi-cycle MIPS datapath
// (shared instruction/data memory, IR, A/B, ALUOut, PC).
// Handles R-type, lw, sw, beq and j. Memory states stall on mem_ready.
// Unsupported opcodes are flagged in DECODE and the sequencer returns to FETCH.
//
// Parameters:
//   USE_MEM_READY  1: stall on mem_ready in memory states; 0: memory always ready
//   STATE_W        width of the state_o debug port (>= 4)
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   opcode           IR[31:26], sampled and latched in DECODE
//   mem_ready        memory completed the current access this cycle
//   pc_write, pc_write_cond, pc_source            PC update controls
//   i_or_d, mem_read, mem_write, ir_write         memory / IR controls
//   mem_to_reg, reg_dst, reg_write                register file controls
//   alu_src_a, alu_src_b, alu_op                  ALU operand / operation selects
//   instr_done       last cycle of each instruction (including illegal ones)
//   illegal_op       unsupported opcode seen in DECODE
//   state_o          current state (debug)
module multicycle_ctrl #(
  parameter int unsigned USE_MEM_READY = 1,
  parameter int unsigned STATE_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_source,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] opc_q;
  logic       rdy;
  logic       op_legal;

  assign rdy      = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
  assign op_legal = (opcode == OP_R) || (opcode == OP_LW) || (opcode == OP_SW) ||
                    (opcode == OP_BEQ) || (opcode == OP_J);

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_R:          state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          default:       state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (opc_q == OP_LW)      state_d = S_MEM_RD;
        else if (opc_q == OP_SW) state_d = S_MEM_WR;
        else                     state_d = S_FETCH;
      end
      S_MEM_RD:   state_d = rdy ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_d = rdy ? S_FETCH : S_MEM_WR;
      S_EXEC:     state_d = S_R_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) opc_q <= opcode;
    end
  end

  // Outputs are decoded from the current state rather than registered: FETCH
  // is Mealy on rdy, and every output must drop to 0 combinationally while
  // rst_n is low.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = '0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = '0;
    alu_op        = '0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    state_o       = '0;
    if (rst_n) begin
      state_o[3:0] = state_q;
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = rdy;
          pc_write  = rdy;
        end
        S_DECODE: begin
          alu_src_b  = 2'b11;
          illegal_op = !op_legal;
          instr_done = !op_legal;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = rdy;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          instr_done    = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = 2'b10;
          instr_done = 1'b1;
        end
        default: begin
          state_o = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into its expected
// per-cycle trace from the instruction-level rules (latency, wait cycles,
// active controls), with random opcodes and memory wait counts.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic [1:0] pcs;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic       done;
    logic       ill;
    logic [3:0] st;
  } ov_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       mem_ready;
  logic [5:0] opcode;

  logic       pcw1, pcwc1, iord1, mrd1, mwr1, irw1, m2r1, rdst1, rw1, asa1, done1, ill1;
  logic [1:0] pcs1, asb1, aop1;
  logic [3:0] st1;
  logic       pcw0, pcwc0, iord0, mrd0, mwr0, irw0, m2r0, rdst0, rw0, asa0, done0, ill0;
  logic [1:0] pcs0, asb0, aop0;
  logic [3:0] st0;

  multicycle_ctrl #(.USE_MEM_READY(1), .STATE_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pcw1), .pc_write_cond(pcwc1), .pc_source(pcs1), .i_or_d(iord1),
    .mem_read(mrd1), .mem_write(mwr1), .ir_write(irw1), .mem_to_reg(m2r1),
    .reg_dst(rdst1), .reg_write(rw1), .alu_src_a(asa1), .alu_src_b(asb1),
    .alu_op(aop1), .instr_done(done1), .illegal_op(ill1), .state_o(st1)
  );

  multicycle_ctrl #(.USE_MEM_READY(0), .STATE_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pcw0), .pc_write_cond(pcwc0), .pc_source(pcs0), .i_or_d(iord0),
    .mem_read(mrd0), .mem_write(mwr0), .ir_write(irw0), .mem_to_reg(m2r0),
    .reg_dst(rdst0), .reg_write(rw0), .alu_src_a(asa0), .alu_src_b(asb0),
    .alu_op(aop0), .instr_done(done0), .illegal_op(ill0), .state_o(st0)
  );

  ov_t o1, o0;
  assign o1 = {pcw1, pcwc1, pcs1, iord1, mrd1, mwr1, irw1, m2r1, rdst1, rw1, asa1, asb1, aop1, done1, ill1, st1};
  assign o0 = {pcw0, pcwc0, pcs0, iord0, mrd0, mwr0, irw0, m2r0, rdst0, rw0, asa0, asb0, aop0, done0, ill0, st0};

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  bit          sel0       = 1'b0;  // 0: check dut1 (stalling), 1: check dut0 (never stalls)
  bit          const0     = 1'b0;  // hold mem_ready at 0 in ignored cycles

  function automatic logic rnd();
    return const0 ? 1'b0 : 1'($urandom_range(0, 1));
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
  endfunction

  task automatic chk(input ov_t e, input string tag);
    ov_t o;
    @(negedge clk);
    o = sel0 ? o0 : o1;
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h (state obs %0d exp %0d)", tag, o, e, o.st, e.st);
    end
    compared++;
    assert (!(o.mrd && o.mwr) && !(o.rw && (o.pcw || o.pcwc))) else begin
      mismatched++;
      $error("FAIL %s_excl: observed %h expected no strobe conflict", tag, o);
    end
  endtask

  task automatic cyc(input ov_t e, input logic rdy, input string tag);
    mem_ready = rdy;
    chk(e, tag);
    @(posedge clk);
    #1;
  endtask

  function automatic ov_t fetch_v(input logic r);
    ov_t e;
    e = '0;
    e.mrd = 1'b1;
    e.asb = 2'b01;
    e.irw = r;
    e.pcw = r;
    return e;
  endfunction

  // Expected trace for one instruction: fw fetch stalls, mw memory stalls
  // (stalls only apply to the stalling instance).
  task automatic run_instr(input logic [5:0] opc, input int unsigned fw, input int unsigned mw);
    ov_t e;
    int unsigned nf, nm, cycles;
    nf = sel0 ? 0 : fw;
    nm = sel0 ? 0 : mw;
    cycles = 0;
    opcode = opc;
    for (int unsigned i = 0; i < nf; i++) begin
      cyc(fetch_v(1'b0), 1'b0, "fetch_wait"); cycles++;
    end
    cyc(fetch_v(1'b1), sel0 ? rnd() : 1'b1, "fetch"); cycles++;
    e = '0; e.st = 4'd1; e.asb = 2'b11;
    if (!legal(opc)) begin e.ill = 1'b1; e.done = 1'b1; end
    cyc(e, rnd(), "decode"); cycles++;
    opcode = 6'($urandom);  // post-DECODE opcode must not matter
    case (opc)
      OP_R: begin
        e = '0; e.st = 4'd6; e.asa = 1'b1; e.aop = 2'b10;
        cyc(e, rnd(), "exec"); cycles++;
        e = '0; e.st = 4'd7; e.rw = 1'b1; e.rdst = 1'b1; e.done = 1'b1;
        cyc(e, rnd(), "r_wb"); cycles++;
      end
      OP_LW, OP_SW: begin
        e = '0; e.st = 4'd2; e.asa = 1'b1; e.asb = 2'b10;
        cyc(e, rnd(), "mem_addr"); cycles++;
        e = '0; e.iord = 1'b1;
        if (opc == OP_LW) begin e.st = 4'd3; e.mrd = 1'b1; end
        else begin e.st = 4'd5; e.mwr = 1'b1; end
        for (int unsigned i = 0; i < nm; i++) begin
          cyc(e, 1'b0, "mem_wait"); cycles++;
        end
        if (opc == OP_SW) e.done = 1'b1;
        cyc(e, sel0 ? rnd() : 1'b1, "mem_access"); cycles++;
        if (opc == OP_LW) begin
          e = '0; e.st = 4'd4; e.rw = 1'b1; e.m2r = 1'b1; e.done = 1'b1;
          cyc(e, rnd(), "mem_wb"); cycles++;
        end
      end
      OP_BEQ: begin
        e = '0; e.st = 4'd8; e.asa = 1'b1; e.aop = 2'b01; e.pcwc = 1'b1; e.pcs = 2'b01; e.done = 1'b1;
        cyc(e, rnd(), "branch"); cycles++;
      end
      OP_J: begin
        e = '0; e.st = 4'd9; e.pcw = 1'b1; e.pcs = 2'b10; e.done = 1'b1;
        cyc(e, rnd(), "jump"); cycles++;
      end
      default: ;
    endcase
    if (cycles > 64) $fatal(1, "FAIL runaway: %0d cycles", cycles);
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] v;
    case ($urandom_range(0, 5))
      0: v = OP_R;
      1: v = OP_LW;
      2: v = OP_SW;
      3: v = OP_BEQ;
      4: v = OP_J;
      default: begin
        v = 6'($urandom);
        while (legal(v)) v = 6'($urandom);
      end
    endcase
    return v;
  endfunction

  initial begin
    ov_t e;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    opcode = '0;
    cyc('0, 1'b1, "reset0");
    cyc('0, 1'b1, "reset1");
    rst_n = 1'b1;

    run_instr(OP_R, 0, 0);
    run_instr(OP_LW, 0, 3);
    run_instr(OP_SW, 1, 2);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 2, 0);
    run_instr(6'b111111, 0, 0);

    // Abort an R-type in EXEC with a two-cycle reset.
    opcode = OP_R;
    cyc(fetch_v(1'b1), 1'b1, "rst_fetch");
    e = '0; e.st = 4'd1; e.asb = 2'b11;
    cyc(e, 1'b1, "rst_decode");
    rst_n = 1'b0;
    cyc('0, 1'b1, "rst_mid0");
    cyc('0, 1'b0, "rst_mid1");
    rst_n = 1'b1;
    run_instr(OP_R, 1, 0);

    for (int i = 0; i < 40; i++)
      run_instr(pick_op(), $urandom_range(0, 3), $urandom_range(0, 3));

    // Non-stalling instance: mem_ready held low throughout, then randomized.
    rst_n = 1'b0;
    sel0 = 1'b1;
    const0 = 1'b1;
    cyc('0, 1'b0, "reset_b");
    rst_n = 1'b1;
    run_instr(OP_LW, 3, 3);
    run_instr(OP_SW, 0, 2);
    const0 = 1'b0;
    for (int i = 0; i < 20; i++)
      run_instr(pick_op(), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
